inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk, reset.
REQ-002 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port in_valid  input  1  request fields valid this cycle.
REQ-005 Port in_ready  output  1  encoder can accept a request this cycle.
REQ-006 Port opcode  input  7  RV32I opcode: 0000011 load, 0010011 ALU-imm, 0100011 store, 1100011 branch, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 0110011 R-type.
REQ-007 Port rd, rs1, rs2  input  5 each  register indices.
REQ-008 Port funct3  input  3; funct7  input  7  function fields.
REQ-009 Port imm  input  32  byte-offset or value immediate, two's complement.
REQ-010 Port halt_on_err  input  1  stop accepting requests after an encode error.
REQ-011 Port err_clr  input  1  one-cycle pulse; leaves ERR state.
REQ-012 Port out_valid  output  1; out_ready  input  1  output handshake.
REQ-013 Port inst_code  output  32  encoded instruction word.
REQ-014 Port out_err  output  2  per-word status: 00 ok, 01 imm out of range, 10 unknown opcode.
REQ-015 Port enc_cnt  output  16  count of words delivered with out_err=00.
REQ-016 Port err_cnt  output  8  count of words delivered with out_err!=00.

Function
REQ-017 Transfers occur on a rising edge where valid and ready are both high.
REQ-018 Output stage SHALL be a 2-entry FIFO; in_ready = (state==RUN) and FIFO not full; in_ready SHALL NOT depend combinationally on out_ready.
REQ-019 Latency: a request accepted at edge N SHALL present out_valid at N+1 when the FIFO was empty; order SHALL be preserved.
REQ-020 Encoding per format: I (load/ALU-imm/JALR) {imm[11:0],rs1,funct3,rd,op}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}; R {funct7,rs2,rs1,funct3,rd,op}.
REQ-021 Range checks, any failure gives out_err=01: I/S imm in [-2048,2047]; B imm in [-4096,4094] with imm[0]=0; J imm in [-1048576,1048574] with imm[0]=0; U imm[11:0]=0.
REQ-022 Unknown opcode SHALL give out_err=10 and inst_code=0; an out-of-range word SHALL still carry the truncated encoding.
REQ-023 FSM states RUN, ERR; RUN->ERR when a word with out_err!=00 is accepted and halt_on_err=1; ERR->RUN on err_clr; in ERR, in_ready=0 and the FIFO continues to drain.
REQ-024 err_clr in RUN SHALL have no effect; err_clr and an erroring accept in the same cycle SHALL leave the FSM in RUN.
REQ-025 enc_cnt and err_cnt SHALL increment on output transfer, wrap at 0xFFFF and saturate at 0xFF respectively.
REQ-026 With the FIFO full and out_ready=1, one entry drains and in_ready rises in the next cycle; with two entries present, simultaneous push and pop SHALL be impossible.
REQ-027 With exactly one entry present, simultaneous push and pop SHALL keep one entry, with the new word at the head.

Reset
REQ-028 On reset: FSM=RUN, FIFO empty, out_valid=0, inst_code=0, out_err=00, enc_cnt=0, err_cnt=0, in_ready=1 in the following cycle.
REQ-029 Reset mid-operation SHALL discard all buffered words without output.

Structure
REQ-030 Opcode constants, the out_err encoding and the FSM state enum SHALL reside in a shared package rv32_pkg, also used by the immediate decoder.
REQ-031 The 2-entry FIFO SHALL be a sub-module enc_fifo2 with push/pop handshake and a parameterised width; encoding logic SHALL be combinational inside inst_encoder.

Verification
REQ-032 ALU-imm, rd=1, rs1=0, funct3=0, imm=-1 -> inst_code 0xFFF00093, out_err 00 at N+1.
REQ-033 Store, rs1=1, rs2=2, funct3=010, imm=8 -> 0x0020A423; branch, rs1=rs2=0, funct3=0, imm=-4 -> 0xFE000EE3.
REQ-034 JAL, rd=1, imm=2048 -> 0x001000EF; JAL imm=3 -> out_err 01.
REQ-035 ALU-imm imm=2048 with halt_on_err=1 -> out_err 01, err_cnt=1, in_ready=0 until err_clr, then 1.
REQ-036 out_ready held 0 for 3 pushes -> in_ready drops after 2 accepts; release -> both words emitted in order, enc_cnt=2.
REQ-037 Reset asserted with 2 words buffered -> out_valid=0 next cycle, counters 0, no words emitted.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I encoder definitions: opcode constants, per-word status codes,
// encoder FSM states and immediate range helpers.
package rv32_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_R      = 7'b0110011;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ERR_W  = 2;

  typedef enum logic [1:0] {
    ERR_OK     = 2'b00,
    ERR_RANGE  = 2'b01,
    ERR_OPCODE = 2'b10
  } enc_err_e;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } enc_state_e;

  // True when v is representable as a two's-complement value of (msb+1) bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
    logic signed [31:0] hi;
    hi = $signed(v) >>> msb;
    return (hi == 32'sd0) || (hi == -32'sd1);
  endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry output buffer with valid/ready handshakes on both sides; the
// push side readiness depends only on local state.
module enc_fifo2
  import rv32_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic [W-1:0] head_r;
  logic [W-1:0] tail_r;
  logic         valid_r;
  logic         full_r;
  logic         push_s;
  logic         pop_s;

  assign push_ready = !full_r;
  assign pop_valid  = valid_r;
  assign pop_data   = head_r;
  assign push_s     = push_valid && !full_r;
  assign pop_s      = valid_r && pop_ready;

  // Entry storage and occupancy; a push during a pop from a single entry lands at the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      valid_r <= 1'b0;
      full_r  <= 1'b0;
    end else begin
      case ({full_r, valid_r})
        2'b00: begin
          if (push_s) begin
            head_r  <= push_data;
            valid_r <= 1'b1;
          end
        end
        2'b01: begin
          if (push_s && pop_s) begin
            head_r <= push_data;
          end else if (push_s) begin
            tail_r <= push_data;
            full_r <= 1'b1;
          end else if (pop_s) begin
            valid_r <= 1'b0;
          end
        end
        2'b11: begin
          if (pop_s) begin
            head_r <= tail_r;
            full_r <= 1'b0;
          end
        end
        default: begin
          valid_r <= 1'b0;
          full_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: combinational field packing and range checks,
// a two-entry output buffer, error-halt FSM and delivery counters.
module inst_encoder
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  input  logic        halt_on_err,
  input  logic        err_clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst_code,
  output logic [1:0]  out_err,
  output logic [15:0] enc_cnt,
  output logic [7:0]  err_cnt
);

  enc_state_e                state_r;
  logic [15:0]               enc_cnt_r;
  logic [7:0]                err_cnt_r;
  logic [INST_W-1:0]         code_s;
  enc_err_e                  err_s;
  logic                      fifo_ready_s;
  logic                      accept_s;
  logic                      deliver_s;
  logic [ERR_W+INST_W-1:0]   fifo_out_s;

  assign in_ready  = (state_r == ST_RUN) && fifo_ready_s;
  assign accept_s  = in_valid && in_ready;
  assign deliver_s = out_valid && out_ready;
  assign inst_code = fifo_out_s[INST_W-1:0];
  assign out_err   = fifo_out_s[ERR_W+INST_W-1:INST_W];
  assign enc_cnt   = enc_cnt_r;
  assign err_cnt   = err_cnt_r;

  // Field packing per instruction format plus immediate range classification.
  always_comb begin
    code_s = 32'd0;
    err_s  = ERR_OK;
    case (opcode)
      OP_LOAD, OP_ALUI, OP_JALR: begin
        code_s = {imm[11:0], rs1, funct3, rd, opcode};
        if (!fits_signed(imm, 32'd11)) err_s = ERR_RANGE;
        else                           err_s = ERR_OK;
      end
      OP_STORE: begin
        code_s = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (!fits_signed(imm, 32'd11)) err_s = ERR_RANGE;
        else                           err_s = ERR_OK;
      end
      OP_BRANCH: begin
        code_s = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        if (!fits_signed(imm, 32'd12) || imm[0]) err_s = ERR_RANGE;
        else                                     err_s = ERR_OK;
      end
      OP_LUI, OP_AUIPC: begin
        code_s = {imm[31:12], rd, opcode};
        if (imm[11:0] != 12'd0) err_s = ERR_RANGE;
        else                    err_s = ERR_OK;
      end
      OP_JAL: begin
        code_s = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (!fits_signed(imm, 32'd20) || imm[0]) err_s = ERR_RANGE;
        else                                     err_s = ERR_OK;
      end
      OP_R: begin
        code_s = {funct7, rs2, rs1, funct3, rd, opcode};
        err_s  = ERR_OK;
      end
      default: begin
        code_s = 32'd0;
        err_s  = ERR_OPCODE;
      end
    endcase
  end

  enc_fifo2 #(.W(ERR_W + INST_W)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (accept_s),
    .push_ready (fifo_ready_s),
    .push_data  ({err_s, code_s}),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (fifo_out_s)
  );

  // Halt FSM: a clear arriving with an erroring accept wins and keeps RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (accept_s && (err_s != ERR_OK) && halt_on_err && !err_clr) state_r <= ST_ERR;
        end
        ST_ERR: begin
          if (err_clr) state_r <= ST_RUN;
        end
        default: state_r <= ST_RUN;
      endcase
    end
  end

  // Delivery counters: good words wrap, errored words saturate.
  always_ff @(posedge clk) begin
    if (reset) begin
      enc_cnt_r <= 16'd0;
      err_cnt_r <= 8'd0;
    end else if (deliver_s) begin
      if (out_err == ERR_OK) enc_cnt_r <= enc_cnt_r + 16'd1;
      else if (err_cnt_r != 8'hFF) err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-computed encodings, halt/clear
// behaviour, output buffering and mid-run reset.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = 7'd0;
  logic [4:0]  rd = 5'd0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [6:0]  funct7 = 7'd0;
  logic [31:0] imm = 32'd0;
  logic        halt_on_err = 1'b0;
  logic        err_clr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] inst_code;
  logic [1:0]  out_err;
  logic [15:0] enc_cnt;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  inst_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .halt_on_err(halt_on_err), .err_clr(err_clr),
    .out_valid(out_valid), .out_ready(out_ready), .inst_code(inst_code),
    .out_err(out_err), .enc_cnt(enc_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
  endtask

  // Called at a falling edge with out_ready=1: one accept, word visible one edge later.
  task automatic do_word(input string tag, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im,
                         input logic [31:0] exp_code, input logic [1:0] exp_err);
    drive(op, d, s1, s2, f3, f7, im);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_code"}, inst_code, exp_code);
    check({tag, "_err"}, {30'd0, out_err}, {30'd0, exp_err});
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_code", inst_code, 32'd0);
    check("rst_err", {30'd0, out_err}, 32'd0);
    check("rst_enc_cnt", {16'd0, enc_cnt}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Encodings, back-to-back so single-entry push+pop is exercised
    out_ready = 1'b1;
    do_word("alui_m1",  7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF, 32'hFFF00093, 2'b00);
    do_word("store",    7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8,         32'h0020A423, 2'b00);
    do_word("br_m4",    7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFC, 32'hFE000EE3, 2'b00);
    do_word("jal_2048", 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048,      32'h001000EF, 2'b00);
    do_word("lui",      7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000,  32'h123452B7, 2'b00);
    do_word("lui_bad",  7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345001,  32'h123452B7, 2'b01);
    do_word("r_sub",    7'b0110011, 5'd1, 5'd2, 5'd3, 3'b000, 7'h20, 32'd0,        32'h403100B3, 2'b00);
    do_word("jalr",     7'b1100111, 5'd0, 5'd1, 5'd0, 3'b000, 7'd0, 32'd0,         32'h00008067, 2'b00);
    do_word("unknown",  7'b1111111, 5'd3, 5'd4, 5'd5, 3'b111, 7'd0, 32'd0,         32'h00000000, 2'b10);
    do_word("br_4094",  7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4094,      32'h7E000FE3, 2'b00);
    do_word("br_4096",  7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4096,      32'h80000063, 2'b01);
    do_word("jal_odd",  7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3,         32'h002000EF, 2'b01);
    @(negedge clk);
    check("mix_enc_cnt", {16'd0, enc_cnt}, 32'd8);
    check("mix_err_cnt", {24'd0, err_cnt}, 32'd4);
    check("mix_drained", {31'd0, out_valid}, 32'd0);

    // Halt on error, blocked requests, then clear
    do_reset();
    halt_on_err = 1'b1;
    do_word("halt", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 32'h80000093, 2'b01);
    check("halt_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("halt_err_cnt", {24'd0, err_cnt}, 32'd1);
    drive(7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
    repeat (2) @(negedge clk);
    check("halt_blocked_valid", {31'd0, out_valid}, 32'd0);
    check("halt_blocked_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_in_ready", {31'd0, in_ready}, 32'd1);
    err_clr = 1'b1;
    do_word("clr_same", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 32'h80000093, 2'b01);
    err_clr = 1'b0;
    check("clr_same_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("clr_same_err_cnt", {24'd0, err_cnt}, 32'd2);
    halt_on_err = 1'b0;

    // Back-pressure: third request refused while full, order kept on release
    do_reset();
    out_ready = 1'b0;
    drive(7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1);
    check("bp_ready0", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    drive(7'b0010011, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2);
    check("bp_ready1", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    drive(7'b0010011, 5'd4, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3);
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    check("bp_head_a", inst_code, 32'h00100113);
    @(negedge clk);
    check("bp_still_full", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_head_b", inst_code, 32'h00200193);
    check("bp_valid_b", {31'd0, out_valid}, 32'd1);
    check("bp_ready_back", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("bp_empty", {31'd0, out_valid}, 32'd0);
    check("bp_enc_cnt", {16'd0, enc_cnt}, 32'd2);

    // Reset with two words buffered discards them
    out_ready = 1'b0;
    drive(7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1);
    @(negedge clk);
    drive(7'b0010011, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    check("rr_full", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rr_out_valid", {31'd0, out_valid}, 32'd0);
    check("rr_enc_cnt", {16'd0, enc_cnt}, 32'd0);
    check("rr_err_cnt", {24'd0, err_cnt}, 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rr_no_emit", {31'd0, out_valid}, 32'd0);
    end
    check("rr_enc_after", {16'd0, enc_cnt}, 32'd0);
    check("rr_in_ready", {31'd0, in_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
